// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush mask generator for an in-order pipeline of STAGES stages.
// Builds a combinational stall mask and a flush mask that can be held for several cycles.
// Also keeps a saturating count of stalled cycles.
// Optional stall watchdog: define STALL_WDT_EN. It inserts one release cycle after
// WDT_LIMIT consecutive stalled cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no stall last cycle, no held flush
// ST_STALL | stall was nonzero last cycle
// ST_FLUSH | held flush mask active (hold count > 0); wins over ST_STALL
module pipe_hazard_ctrl #(
   parameter int STAGES       = 6,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16,
   parameter int WDT_LIMIT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stall_req,
   input  logic [STAGES-1:0] flush_req,
   input  logic              stop_stall,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              wdt_timeout
);

   localparam int HCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [STAGES-1:0] held_q, held_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [STAGES-1:0] stall_mask;
   logic [STAGES-1:0] new_mask;
   logic              wdt_release;

   // Thermometer masks: stall holds every stage at or below the oldest requester,
   // flush squashes every stage strictly younger than the oldest redirecting stage.
   always_comb begin
      stall_mask = '0;
      new_mask   = '0;
      for (int k = 0; k < STAGES; k++) begin
         stall_mask[k] = |(stall_req >> k);
         new_mask[k]   = |(flush_req >> (k + 1));
      end
   end

   assign stall = (rst || stop_stall || wdt_release) ? '0 : stall_mask;
   assign flush = rst ? '0 : (new_mask | ((state_q == ST_FLUSH) ? held_q : '0));
   assign stall_cnt = stall_cnt_q;

   // Next-state for flush hold, FSM and the saturating stall counter.
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      held_d      = held_q;
      stall_cnt_d = stall_cnt_q;
      if (|new_mask) begin
         // A single-cycle flush needs no hold, so the registers stay at zero.
         held_d     = (FLUSH_CYCLES > 1) ? (held_q | new_mask) : '0;
         hold_cnt_d = HCW'(FLUSH_CYCLES - 1);
      end else if ((hold_cnt_q != '0) && (stall == '0)) begin
         hold_cnt_d = hold_cnt_q - HCW'(1);
         if (hold_cnt_q == HCW'(1)) begin
            held_d = '0;
         end
      end
      if (hold_cnt_d != '0) begin
         state_d = ST_FLUSH;
      end else if (stall != '0) begin
         state_d = ST_STALL;
      end else begin
         state_d = ST_IDLE;
      end
      if (stall[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, flush hold and statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
         held_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         held_q      <= held_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef STALL_WDT_EN
   localparam int WW = (WDT_LIMIT > 2) ? $clog2(WDT_LIMIT) : 1;

   logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
   logic          wdt_rel_q, wdt_rel_d;

   // Count consecutive stalled cycles; the edge after the last allowed one opens a release cycle.
   always_comb begin
      wdt_rel_d = stall[0] && (wdt_cnt_q == WW'(WDT_LIMIT - 1));
      wdt_cnt_d = (stall[0] && !wdt_rel_d) ? (wdt_cnt_q + WW'(1)) : '0;
   end

   // Watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_q <= '0;
         wdt_rel_q <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_rel_q <= wdt_rel_d;
      end
   end

   assign wdt_release = wdt_rel_q;
   assign wdt_timeout = wdt_rel_q;
`else
   assign wdt_release = 1'b0;
   assign wdt_timeout = 1'b0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the in-order core. It generalises the fixed six-stage stall mask to `STAGES` stages, with a request line per stage. It adds multi-cycle flush hold, a saturating stall-cycle counter, and an optional stall watchdog. It sits beside the pipeline registers and drives their stall and flush inputs.

## Interface
- `STAGES`, 6: number of pipeline stages; stage 0 is IF (youngest), stage `STAGES-1` is WB.
- `FLUSH_CYCLES`, 1: total cycles a flush mask stays asserted (≥1).
- `CNT_W`, 16: width of the stall statistics counter.
- `WDT_LIMIT`, 1024: consecutive stalled cycles before the watchdog fires (≥2; used only with the watchdog).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_req` in `STAGES`: bit i set means stage i cannot advance this cycle.
- `flush_req` in `STAGES`: bit i set means stage i resolved a redirect; younger stages 0..i-1 must be squashed.
- `stop_stall` in 1: forces the stall output to zero this cycle.
- `stall` out `STAGES`: bit k set holds pipeline register k.
- `flush` out `STAGES`: bit k set invalidates pipeline register k.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `stall[0]`=1.
- `wdt_timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- Stall mask (combinational, zero latency):
  - h = highest set index of `stall_req`.
  - `stall[k]`=1 for all k≤h, else 0.
  - All zeros when `stall_req`=0, `stop_stall`=1, `rst`=1, or a watchdog release cycle is active.
  - Example, STAGES=6: req bit 4 → 6'b011111; req bit 1 → 6'b000011; bits 1 and 4 → 6'b011111.
- Flush mask:
  - f = highest set index of `flush_req`.
  - New mask M: bits 0..f-1 set; f=0 gives M=0.
  - Same cycle: `flush` = M OR the held mask.
  - M is latched into the held mask with hold count `FLUSH_CYCLES-1`.
  - A new `flush_req` while holding: latched = held OR M, and the count reloads.
- Flush/stall interaction:
  - `stall` and `flush` may both be set.
  - While `stall` is nonzero, the flush hold count does not decrement.
  - `stop_stall` does not affect flush.
- State machine, registered:
  - IDLE: no stall, no held flush.
  - STALL: previous cycle had `stall`≠0.
  - FLUSH: hold count > 0.
  - FLUSH has priority over STALL for state encoding only; outputs follow the rules above.
  - Transitions are evaluated every cycle from the current-cycle outputs.
- `stall_cnt`: increments when `stall[0]`=1; saturates at all-ones; never wraps.

## Timing
- Reset values: `stall`=0, `flush`=0, `stall_cnt`=0, `wdt_timeout`=0, hold count=0, held mask=0, state=IDLE.
- Reset asserted mid-flush or mid-stall clears everything immediately (asynchronously).
- `stall` and the new-flush part of `flush` are combinational from inputs: 0-cycle latency.
- Held flush bits persist exactly `FLUSH_CYCLES` unstalled cycles in total, counting the request cycle.
- With `FLUSH_CYCLES`=1, the hold registers stay zero.
- `stall_cnt` updates on the clock edge after the stalled cycle.

## Configuration
- Macro: `STALL_WDT_EN`.
- Defined:
  - A consecutive-stall counter increments each cycle `stall[0]`=1 and clears on any cycle with `stall[0]`=0.
  - When it equals `WDT_LIMIT-1` at a clock edge, the next cycle is a release cycle: `stall` forced 0, `wdt_timeout`=1, counter cleared.
  - Stalling resumes the following cycle if `stall_req` is still set.
- Undefined: no watchdog logic; `wdt_timeout` is tied to 0; `WDT_LIMIT` is ignored.

## Test plan
- Reset, then `stall_req`=6'b010000 → `stall`=6'b011111; add bit 1 → still 6'b011111; only bit 1 → 6'b000011.
- `stall_req`=6'b010000 with `stop_stall`=1 → `stall`=0; `stall_cnt` unchanged next cycle.
- `FLUSH_CYCLES`=3, `flush_req`=6'b001000 for one cycle → `flush`=6'b000111 for exactly 3 cycles, then 0. Repeat with `stall_req` bit 4 held 2 cycles mid-flush → flush extends by 2 cycles.
- `CNT_W`=4, stall 20 cycles → `stall_cnt` reaches 15 and holds.
- With `STALL_WDT_EN`, `WDT_LIMIT`=4, `stall_req`=1 held → `stall`=1 for 4 cycles, then 1 cycle of `stall`=0 with `wdt_timeout`=1, then stalls again; without the macro, `wdt_timeout` stays 0.
- Assert `rst` during a held flush and stall → all outputs 0 immediately; after release, state is IDLE and no flush residue remains.
